// File: rtl/hud_text_reader_pkg.sv
// Shared constants, fetch FSM state type and next-line helper for the HUD text reader.
package hud_text_pkg;

    localparam int unsigned CHAR_W  = 8;
    localparam int unsigned CHAR_H  = 16;
    localparam int unsigned FONT_AW = 11;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } fetch_state_t;

    function automatic logic [9:0] next_line(input logic [9:0] y, input int unsigned v_total);
        return (y == 10'(v_total - 1)) ? 10'd0 : y + 10'd1;
    endfunction

endpackage

// File: rtl/hud_text_reader_if.sv
// Video-timing, text RAM and font ROM signals of the HUD text reader.
interface hud_text_reader_if;
    import hud_text_pkg::*;

    logic [9:0]         DrawX;
    logic [9:0]         DrawY;
    logic [7:0]         read_address;
    logic [7:0]         data_Out;
    logic [FONT_AW-1:0] font_addr;
    logic [7:0]         font_data;
    logic               text_pixel_on;
    logic               busy;

    modport master (
        output DrawX, DrawY, data_Out, font_data,
        input  read_address, font_addr, text_pixel_on, busy
    );

    modport slave (
        input  DrawX, DrawY, data_Out, font_data,
        output read_address, font_addr, text_pixel_on, busy
    );

endinterface

// File: rtl/hud_text_reader_line_buffer.sv
// One text row of characters: synchronous write/clear, asynchronous read.
module hud_line_buffer #(
    parameter int unsigned COLS = 40,
    parameter int unsigned IW   = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [7:0]    wr_data,
    input  logic [IW-1:0] rd_idx,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [COLS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < COLS; i++) begin
                mem[IW'(i)] <= '0;
            end
        end else if (wr_en && (wr_idx < IW'(COLS))) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Columns past the row read as a blank character.
    assign rd_data = (rd_idx < IW'(COLS)) ? mem[rd_idx] : '0;

endmodule

// File: rtl/hud_text_reader.sv
// HUD text reader: copies the next text row into a line buffer during h-blank and
// renders glyph pixels via the font ROM. Optional blink attribute: HUD_TEXT_BLINK_EN.
module hud_text_reader
    import hud_text_pkg::*;
#(
    parameter int unsigned COLS     = 40,
    parameter int unsigned ROWS     = 4,
    parameter int unsigned X0       = 0,
    parameter int unsigned Y0       = 0,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_TOTAL  = 525
) (
    input  logic             Clk,
    input  logic             Reset,
    hud_text_reader_if.slave bus
);

    localparam int unsigned IW     = 6;
    localparam int unsigned TEXT_W = CHAR_W * COLS;
    localparam int unsigned BAND_H = CHAR_H * ROWS;

    fetch_state_t  state;
    logic [IW-1:0] k;

    logic [9:0]    ny;
    logic [9:0]    ny_off;
    logic          next_in_band;
    logic [7:0]    fetch_base;

    logic          lb_wr_en;
    logic [IW-1:0] lb_wr_idx;
    logic [IW-1:0] lb_rd_idx;
    logic [7:0]    c;

    logic [9:0]    dx;
    logic [9:0]    dy;
    logic          in_text;
    logic          blank_char;
    logic          in_text_d;
    logic          blank_d;
    logic [2:0]    x_d;

    assign ny     = next_line(bus.DrawY, V_TOTAL);
    assign ny_off = ny - 10'(Y0);
    // Offsets below the band origin wrap to large values, so one compare checks both bounds.
    assign next_in_band = ny_off < 10'(BAND_H);
    assign fetch_base   = 8'(ny_off[9:4]) * 8'(COLS);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state            <= IDLE;
            k                <= '0;
            bus.read_address <= '0;
            bus.busy         <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if ((bus.DrawX == 10'(H_ACTIVE)) && next_in_band) begin
                        state            <= FETCH;
                        k                <= '0;
                        bus.read_address <= fetch_base;
                        bus.busy         <= 1'b1;
                    end
                end
                FETCH: begin
                    k <= k + IW'(1);
                    if (k == IW'(COLS - 1)) begin
                        state <= DRAIN;
                    end else begin
                        bus.read_address <= bus.read_address + 8'd1;
                    end
                end
                DRAIN: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

    // RAM data trails the address by one cycle; k has advanced to COLS by DRAIN.
    assign lb_wr_en  = ((state == FETCH) && (k != '0)) || (state == DRAIN);
    assign lb_wr_idx = k - IW'(1);

    hud_line_buffer #(
        .COLS (COLS),
        .IW   (IW)
    ) u_line_buffer (
        .clk     (Clk),
        .rst     (Reset),
        .wr_en   (lb_wr_en),
        .wr_idx  (lb_wr_idx),
        .wr_data (bus.data_Out),
        .rd_idx  (lb_rd_idx),
        .rd_data (c)
    );

    assign dx        = bus.DrawX - 10'(X0);
    assign dy        = bus.DrawY - 10'(Y0);
    assign in_text   = (dx < 10'(TEXT_W)) && (dy < 10'(BAND_H));
    assign lb_rd_idx = dx[IW+2:3];

`ifdef HUD_TEXT_BLINK_EN
    logic [9:0] frame_cnt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_cnt <= '0;
        end else if ((bus.DrawX == 10'd0) && (bus.DrawY == 10'd0)) begin
            frame_cnt <= frame_cnt + 10'd1;
        end
    end

    assign blank_char = (c[6:0] == 7'd0) || (c[7] && frame_cnt[5]);
`else
    logic unused_attr;

    assign unused_attr = c[7];
    assign blank_char  = (c[6:0] == 7'd0);
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            bus.font_addr     <= '0;
            in_text_d         <= 1'b0;
            blank_d           <= 1'b0;
            x_d               <= '0;
            bus.text_pixel_on <= 1'b0;
        end else begin
            bus.font_addr     <= {c[6:0], dy[3:0]};
            in_text_d         <= in_text;
            blank_d           <= blank_char;
            x_d               <= bus.DrawX[2:0];
            bus.text_pixel_on <= in_text_d && !blank_d && bus.font_data[3'd7 - x_d];
        end
    end

endmodule

// File: tb/tb_hud_text_reader.sv
// Randomized bench for hud_text_reader against a row-level reference model.
module tb_hud_text_reader;

    localparam int COLS     = 40;
    localparam int ROWS     = 4;
    localparam int X0       = 0;
    localparam int Y0       = 0;
    localparam int H_ACTIVE = 640;
    localparam int V_TOTAL  = 525;
    localparam int H_TOTAL  = 800;

`ifdef HUD_TEXT_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    hud_text_reader_if bus ();

    hud_text_reader #(
        .COLS     (COLS),
        .ROWS     (ROWS),
        .X0       (X0),
        .Y0       (Y0),
        .H_ACTIVE (H_ACTIVE),
        .V_TOTAL  (V_TOTAL)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    logic [7:0] ram      [256];
    logic [7:0] font_rom [2048];

    always @(posedge Clk) bus.data_Out <= ram[bus.read_address];
    assign bus.font_data = font_rom[bus.font_addr];

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [7:0]  m_lb [COLS];
    int          m_frame   = 0;
    int          fetch_pos = -1;
    int          fetch_row = 0;
    logic [7:0]  m_ra      = '0;
    bit          m_pend    = 1'b0;

    bit          line_pix [H_TOTAL];
    logic [10:0] line_fa  [H_TOTAL];
    int          line_busy;
    logic [7:0]  ra_at_trigger;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int next_y(input int y);
        return (y == V_TOTAL - 1) ? 0 : y + 1;
    endfunction

    function automatic bit in_band(input int y);
        return (y >= Y0) && (y < Y0 + 16 * ROWS);
    endfunction

    function automatic bit in_text(input int x, input int y);
        return (x >= X0) && (x < X0 + 8 * COLS) && in_band(y);
    endfunction

    function automatic bit ref_pixel(input int x, input int y);
        logic [7:0]  ch;
        logic [7:0]  row;
        logic [10:0] a;
        if (!in_text(x, y)) return 1'b0;
        ch = m_lb[(x - X0) / 8];
        if (ch[6:0] == 7'd0) return 1'b0;
        if (BLINK && ch[7] && ((m_frame % 64) >= 32)) return 1'b0;
        a   = {ch[6:0], 4'((y - Y0) % 16)};
        row = font_rom[a];
        return row[7 - ((x - X0) % 8)];
    endfunction

    task automatic step(input int x, input int y, input bit rst);
        bit          pix_now;
        bit          exp_pix;
        bit          chk_fa;
        logic [7:0]  ch;
        logic [10:0] fa_exp;
        bus.DrawX = 10'(x);
        bus.DrawY = 10'(y);
        Reset     = rst;
        pix_now   = ref_pixel(x, y);
        chk_fa    = in_text(x, y);
        fa_exp    = '0;
        if (chk_fa) begin
            ch     = m_lb[(x - X0) / 8];
            fa_exp = {ch[6:0], 4'((y - Y0) % 16)};
        end
        @(posedge Clk);
        #1;
        if (rst) begin
            for (int i = 0; i < COLS; i++) m_lb[i] = '0;
            m_frame   = 0;
            fetch_pos = -1;
            m_ra      = '0;
            m_pend    = 1'b0;
            exp_pix   = 1'b0;
            fa_exp    = '0;
            chk_fa    = 1'b1;
        end else begin
            exp_pix = m_pend;
            m_pend  = pix_now;
            if (fetch_pos >= 0) begin
                fetch_pos++;
                if (fetch_pos <= COLS - 1) m_ra = 8'(fetch_row * COLS + fetch_pos);
                if (fetch_pos == COLS + 1) begin
                    for (int i = 0; i < COLS; i++) m_lb[i] = ram[fetch_row * COLS + i];
                    fetch_pos = -1;
                end
            end else if ((x == H_ACTIVE) && in_band(next_y(y))) begin
                fetch_row     = (next_y(y) - Y0) / 16;
                fetch_pos     = 0;
                m_ra          = 8'(fetch_row * COLS);
                ra_at_trigger = bus.read_address;
            end
            if ((x == 0) && (y == 0)) m_frame++;
        end
        check($sformatf("busy x=%0d y=%0d", x, y), 32'(bus.busy), 32'(fetch_pos >= 0));
        check($sformatf("read_address x=%0d y=%0d", x, y), 32'(bus.read_address), 32'(m_ra));
        check($sformatf("text_pixel_on x=%0d y=%0d", x, y), 32'(bus.text_pixel_on), 32'(exp_pix));
        if (chk_fa) check($sformatf("font_addr x=%0d y=%0d", x, y), 32'(bus.font_addr), 32'(fa_exp));
        if (bus.busy) line_busy++;
        if (x >= 1) line_pix[x - 1] = bus.text_pixel_on;
        line_fa[x] = bus.font_addr;
    endtask

    task automatic run_line(input int y, input int rst_x);
        line_busy = 0;
        for (int x = 0; x < H_TOTAL; x++) begin
            step(x, y, (rst_x >= 0) && (x >= rst_x) && (x < rst_x + 3));
        end
    endtask

    function automatic int lit_range(input int lo, input int hi);
        int n = 0;
        for (int x = lo; x < hi; x++) n += int'(line_pix[x]);
        return n;
    endfunction

    task automatic reset_pulse();
        for (int i = 0; i < 3; i++) step(0, 100, 1'b1);
    endtask

    initial begin
        string       score;
        logic [7:0]  s_pat;
        logic [10:0] fa0;
        int          y;

        for (int i = 0; i < 2048; i++) font_rom[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
        font_rom[{7'h53, 4'd0}] = 8'h3C;
        for (int r = 0; r < 16; r++) font_rom[{7'h30, 4'(r)}] = 8'hFF;

        reset_pulse();
        check("reset font_addr", 32'(bus.font_addr), 32'd0);
        check("reset text_pixel_on", 32'(bus.text_pixel_on), 32'd0);

        // Abandon a fetch at k=10, then show the buffer was cleared.
        run_line(15, -1);
        run_line(15, H_ACTIVE + 11);
        check("mid-fetch reset busy cycles", 32'(line_busy), 32'd11);
        run_line(16, -1);
        check("cleared buffer lit pixels", 32'(lit_range(0, 8 * COLS)), 32'd0);

        score = "Score:0";
        for (int i = 0; i < 7; i++) ram[i] = score[i];
        ram[7] = 8'h00;
        run_line(V_TOTAL - 1, -1);
        check("wrap fetch first address", 32'(ra_at_trigger), 32'd0);
        check("wrap fetch busy cycles", 32'(line_busy), 32'(COLS + 1));

        run_line(0, -1);
        fa0 = line_fa[0];
        check("lb0 glyph", 32'(fa0[10:4]), 32'h53);
        s_pat = 8'h3C;
        for (int x = 0; x < 8; x++) begin
            check($sformatf("S row0 px%0d", x), 32'(line_pix[x]), 32'(s_pat[7 - x]));
        end

        run_line(80, -1);
        check("out of band lit pixels", 32'(lit_range(0, H_TOTAL - 1)), 32'd0);
        check("out of band busy cycles", 32'(line_busy), 32'd0);

        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
            y = ($urandom_range(0, 3) == 0) ? int'($urandom_range(500, V_TOTAL - 1))
                                            : int'($urandom_range(0, 70));
            run_line(y, -1);
        end

        reset_pulse();
        ram[3] = 8'hB0;
        run_line(V_TOTAL - 1, -1);
        run_line(0, -1);
        check("char3 frame 1 lit", 32'(lit_range(24, 32) > 0), 32'd1);
        for (int i = 0; i < 31; i++) step(0, 0, 1'b0);
        run_line(0, -1);
        check("char3 frame 33 lit", 32'(lit_range(24, 32) > 0), 32'(!BLINK));
        for (int i = 0; i < 30; i++) step(0, 0, 1'b0);
        run_line(0, -1);
        check("char3 frame 64 lit", 32'(lit_range(24, 32) > 0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
